ps2_host_cmd: RTL and testbench

Host-to-device command sequencer for the PS/2 keyboard port. The CPU writes a command byte, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), through a two-register bus window. The block performs the PS/2 host request: clock inhibit, start bit, 8 data bits, odd parity, stop bit and device ACK bit. It then waits for the device response byte from the existing receive path, retrying on resend or timeout. It sits beside the keyboard receiver, shares the `ps2_clock`/`ps2_data` open-drain pins with it, and holds the receiver off the lines while transmitting.

---
 rtl/ps2_host_cmd_if.sv | 24 ++
 rtl/ps2_host_cmd.sv | 198 +++++++++++++++++++
 tb/tb_ps2_host_cmd.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_cmd_if.sv
// CPU register window plus receiver hand-off signals of the PS/2 command sequencer.
// Combinational bundle: no latency of its own.
// rx_valid/rx_ack form a hold/release handshake; the receiver holds its byte until rx_ack.
interface ps2_host_cmd_if;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic       addr;
    logic       we;
    logic       cs;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ack;
    logic       rx_inhibit;

    modport slave (
        output dbr, rx_ack, rx_inhibit,
        input  dbw, addr, we, cs, rx_valid, rx_byte
    );

    modport master (
        input  dbr, rx_ack, rx_inhibit,
        output dbw, addr, we, cs, rx_valid, rx_byte
    );
endinterface

// File: rtl/ps2_host_cmd.sv
// PS/2 host-to-device command sequencer: inhibit, 11-bit request frame, device response with retry.
// Latency: busy/clk inhibit one cycle after the write; data changes one cycle after each detected clock fall.
// Backpressure: command writes are dropped while busy; the receiver byte is held until rx_ack.
module ps2_host_cmd #(
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 240000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_host_cmd_if.slave  bus,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACKBIT, S_LINEIDLE, S_WAITRSP, S_RETRY
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]       retries_q, retries_d;
    logic             done_q, done_d, ok_q, ok_d;
    logic             err_nak_q, err_nak_d, err_tmo_q, err_tmo_d;
    logic             cause_tmo_q, cause_tmo_d;
    logic             data_oe_q, data_oe_d;
    logic             clk_q;
    logic [7:0]       resp_q, resp_d;
    logic [7:0]       dbr_q, dbr_d;

    logic       fall, timeout, wr_cmd;
    logic [7:0] status;

    assign fall    = clk_q & ~ps2_clk_in;
    assign wr_cmd  = bus.cs & bus.we & ~bus.addr;
    assign timeout = (state_q inside {S_INHIBIT, S_START, S_SEND, S_ACKBIT, S_LINEIDLE, S_WAITRSP})
                     && (tmo_cnt_q == TMO_MAX);
    assign status  = {state_q != S_IDLE, done_q, ok_q, err_nak_q, err_tmo_q, retries_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retries_q   <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_nak_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            cause_tmo_q <= 1'b0;
            data_oe_q   <= 1'b0;
            clk_q       <= 1'b1;
            resp_q      <= '0;
            dbr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retries_q   <= retries_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            err_nak_q   <= err_nak_d;
            err_tmo_q   <= err_tmo_d;
            cause_tmo_q <= cause_tmo_d;
            data_oe_q   <= data_oe_d;
            clk_q       <= ps2_clk_in;
            resp_q      <= resp_d;
            dbr_q       <= dbr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retries_d   = retries_q;
        done_d      = done_q;
        ok_d        = ok_q;
        err_nak_d   = err_nak_q;
        err_tmo_d   = err_tmo_q;
        cause_tmo_d = cause_tmo_q;
        data_oe_d   = data_oe_q;
        resp_d      = resp_q;
        dbr_d       = dbr_q;

        if (state_q != S_IDLE && tmo_cnt_q != TMO_MAX)
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

        // Timeout wins over any fall or rx_valid seen in the same cycle.
        if (timeout) begin
            state_d     = S_RETRY;
            data_oe_d   = 1'b0;
            cause_tmo_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (wr_cmd) begin
                    cmd_d     = bus.dbw;
                    done_d    = 1'b0;
                    ok_d      = 1'b0;
                    err_nak_d = 1'b0;
                    err_tmo_d = 1'b0;
                    retries_d = '0;
                    inh_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
                S_INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        data_oe_d = 1'b1;
                        state_d   = S_START;
                    end else begin
                        inh_cnt_d = inh_cnt_q + INH_W'(1);
                    end
                end
                S_START: begin
                    bit_cnt_d = '0;
                    state_d   = S_SEND;
                end
                S_SEND: if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~cmd_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ^cmd_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACKBIT;
                    end
                end
                S_ACKBIT: if (fall) begin
                    if (ps2_data_in) begin
                        cause_tmo_d = 1'b0;
                        state_d     = S_RETRY;
                    end else begin
                        state_d     = S_LINEIDLE;
                    end
                end
                S_LINEIDLE: if (ps2_clk_in && ps2_data_in) state_d = S_WAITRSP;
                S_WAITRSP: if (bus.rx_valid) begin
                    resp_d = bus.rx_byte;
                    if (bus.rx_byte == 8'hFA) begin
                        done_d  = 1'b1;
                        ok_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.rx_byte == 8'hFE) begin
                        cause_tmo_d = 1'b0;
                        state_d     = S_RETRY;
                    end else begin
                        done_d    = 1'b1;
                        err_nak_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_RETRY: begin
                    if (retries_q < 3'(MAX_RETRY)) begin
                        retries_d = retries_q + 3'd1;
                        inh_cnt_d = '0;
                        tmo_cnt_d = '0;
                        state_d   = S_INHIBIT;
                    end else begin
                        done_d    = 1'b1;
                        err_tmo_d = cause_tmo_q;
                        err_nak_d = ~cause_tmo_q;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bus.cs && !bus.we)
            dbr_d = bus.addr ? resp_q : status;
    end

    always_comb begin
        ps2_clk_oe     = (state_q == S_INHIBIT);
        bus.rx_inhibit = state_q inside {S_INHIBIT, S_START, S_SEND, S_ACKBIT, S_LINEIDLE};
        bus.rx_ack     = (state_q == S_WAITRSP) && bus.rx_valid && !timeout;
    end

    assign ps2_data_oe = data_oe_q;
    assign bus.dbr     = dbr_q;
endmodule

// File: tb/tb_ps2_host_cmd.sv
// Directed bench for ps2_host_cmd: open-drain device model, register reads checked through a scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_cmd;
    localparam int INH  = 1200;
    localparam int TMO  = 4000;
    localparam int HALF = 8;

    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    ps2_host_cmd_if bus();

    ps2_host_cmd #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain lines: either side pulling low wins.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int n_inh = 0;
    int rise_q[$];
    rd_exp_t exp_rd_q[$];
    logic [9:0] exp_frame_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        tick();
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.dbw = d;
        tick();
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic a, input logic [7:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        exp_rd_q.push_back(e);
        tick();
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        tick();
        bus.cs = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        ok = 1'b1;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3 * TMO) begin
            chk("dev_wait_start_bound", 0, 1);
            ok = 1'b0;
        end
    endtask

    // Device clocks 10 bits, samples before each rising edge, then drives the ACK bit.
    task automatic dev_frame(input logic ack_low);
        logic [9:0] obs;
        bit ok;
        wait_start(ok);
        if (!ok) return;
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) tick();
            obs[k] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HALF) tick();
        end
        dev_data = ~ack_low;
        repeat (2) tick();
        dev_clk = 1'b0;
        repeat (HALF) tick();
        dev_clk = 1'b1;
        repeat (HALF) tick();
        dev_data = 1'b1;
        if (exp_frame_q.size() == 0) chk("frame_unexpected", {22'd0, obs}, 32'hFFFF_FFFF);
        else chk("frame_bits", {22'd0, obs}, {22'd0, exp_frame_q.pop_front()});
    endtask

    task automatic send_rsp(input logic [7:0] b);
        bit seen = 1'b0;
        tick();
        bus.rx_valid = 1'b1; bus.rx_byte = b;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.rx_ack) seen = 1'b1;
        end
        tick();
        bus.rx_valid = 1'b0;
        chk("rx_ack_seen", seen, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.rx_ack) ack_cnt++;
    end

    // Inhibit pulse monitor: length of every clock-low pulse and the start bit that follows it.
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (ps2_clk_oe) begin
                if (run == 0) begin
                    n_inh++;
                    rise_q.push_back(cyc);
                end
                run++;
            end else if (run > 0) begin
                chk("inhibit_len", run, INH);
                chk("start_data_oe", ps2_data_oe, 1);
                run = 0;
            end
        end
    end

    // Read scoreboard: any bus read pops the expected value queued when it was issued.
    initial forever begin
        @(posedge clk);
        if (bus.cs && !bus.we) begin
            @(negedge clk);
            if (exp_rd_q.size() == 0) begin
                chk("rd_unexpected", {24'd0, bus.dbr}, 32'hFFFF_FFFF);
            end else begin
                rd_exp_t e;
                e = exp_rd_q.pop_front();
                chk(e.name, {24'd0, bus.dbr}, {24'd0, e.val});
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0, inh0, sp;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.dbw = '0;
        bus.rx_valid = 1'b0; bus.rx_byte = '0;
        #3;
        chk("rst_dbr", {24'd0, bus.dbr}, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_rx_ack", bus.rx_ack, 0);
        chk("rst_rx_inhibit", bus.rx_inhibit, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        rd(1'b0, 8'h00, "rst_status");

        // 0xED: data 1,0,1,1,0,1,1,1 LSB-first, odd parity 1, stop 1.
        acks0 = ack_cnt;
        exp_frame_q.push_back(10'h3ED);
        wr(1'b0, 8'hED);
        rd(1'b0, 8'h80, "ed_busy");
        chk("ed_rx_inhibit", bus.rx_inhibit, 1);
        dev_frame(1'b1);
        send_rsp(8'hFA);
        rd(1'b0, 8'h60, "ed_status");
        rd(1'b1, 8'hFA, "ed_resp");
        chk("ed_ack_pulses", ack_cnt - acks0, 1);

        // 0xF4 (parity 0), resend once then ACK.
        inh0 = n_inh;
        exp_frame_q.push_back(10'h2F4);
        exp_frame_q.push_back(10'h2F4);
        wr(1'b0, 8'hF4);
        dev_frame(1'b1);
        send_rsp(8'hFE);
        dev_frame(1'b1);
        send_rsp(8'hFA);
        rd(1'b0, 8'h61, "f4_status");
        rd(1'b1, 8'hFA, "f4_resp");
        chk("f4_inhibit_pulses", n_inh - inh0, 2);

        // Silent device: four attempts, each ended by the timeout.
        inh0 = n_inh;
        wr(1'b0, 8'hF2);
        repeat (4 * (TMO + 2) + 40) tick();
        chk("tmo_attempts", n_inh - inh0, 4);
        if (n_inh - inh0 == 4) begin
            for (int i = 1; i < 4; i++) begin
                sp = rise_q[inh0 + i] - rise_q[inh0 + i - 1];
                chk("tmo_spacing", (sp >= TMO && sp <= TMO + 2), 1);
            end
        end
        chk("tmo_clk_oe", ps2_clk_oe, 0);
        chk("tmo_data_oe", ps2_data_oe, 0);
        rd(1'b0, 8'h4B, "tmo_status");

        // NAK on every attempt; 0xF5 has parity 1.
        acks0 = ack_cnt;
        for (int i = 0; i < 4; i++) exp_frame_q.push_back(10'h3F5);
        wr(1'b0, 8'hF5);
        for (int i = 0; i < 4; i++) dev_frame(1'b0);
        repeat (10) tick();
        rd(1'b0, 8'h53, "nak_status");
        chk("nak_no_rx_ack", ack_cnt - acks0, 0);

        // Write while busy is dropped; rx_valid in IDLE is never acknowledged.
        exp_frame_q.push_back(10'h3FF);
        wr(1'b0, 8'hFF);
        repeat (5) tick();
        wr(1'b0, 8'h55);
        dev_frame(1'b1);
        send_rsp(8'hFA);
        rd(1'b0, 8'h60, "busy_wr_status");
        acks0 = ack_cnt;
        tick();
        bus.rx_valid = 1'b1; bus.rx_byte = 8'h12;
        repeat (20) tick();
        bus.rx_valid = 1'b0;
        chk("idle_no_rx_ack", ack_cnt - acks0, 0);
        rd(1'b1, 8'hFA, "idle_resp_kept");

        // Asynchronous reset while the host drives bit 4 of 0xED (a 0, so data is pulled low).
        wr(1'b0, 8'hED);
        rd(1'b0, 8'h80, "pre_rst_busy");
        begin
            bit ok;
            wait_start(ok);
            if (ok) begin
                repeat (3) tick();
                for (int k = 0; k < 4; k++) begin
                    dev_clk = 1'b0;
                    repeat (HALF) tick();
                    dev_clk = 1'b1;
                    repeat (HALF) tick();
                end
                dev_clk = 1'b0;
                repeat (3) tick();
                chk("bit4_data_oe", ps2_data_oe, 1);
                chk("bit4_rx_inhibit", bus.rx_inhibit, 1);
                #1 rst_n = 1'b0;
                #1;
                chk("arst_clk_oe", ps2_clk_oe, 0);
                chk("arst_data_oe", ps2_data_oe, 0);
                chk("arst_rx_inhibit", bus.rx_inhibit, 0);
                chk("arst_dbr", {24'd0, bus.dbr}, 0);
            end
        end
        repeat (3) tick();
        dev_clk = 1'b1;
        rst_n = 1'b1;
        repeat (3) tick();
        rd(1'b0, 8'h00, "post_rst_status");

        repeat (4) tick();
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("frame_queue_drained", exp_frame_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
